// File: rtl/tour_length_eval.sv
// Scores a closed TSP tour: Manhattan length over a snapshotted visit order,
// a permutation check, and a running best over valid tours since reset.
module tour_length_eval #(
  parameter int N  = 64,
  parameter int IW = 6,
  parameter int CW = 8,
  parameter int OW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N*CW-1:0]   xs,
  input  logic [N*CW-1:0]   ys,
  input  logic [N*IW-1:0]   path,
  output logic              busy,
  output logic              done,
  output logic [OW-1:0]     length,
  output logic              perm_ok,
  output logic [OW-1:0]     best,
  output logic              best_upd,
  output logic [1:0]        state_dbg
);

  // Handshake: start is a request sampled only in IDLE (no ready, no queueing);
  // busy marks RUN and done is a one-cycle result strobe that replaces busy.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t            state_q;
  logic [IW-1:0]     snap_q [N];
  logic [IW-1:0]     idx_q;
  logic [OW-1:0]     acc_q, acc_d;
  logic [N-1:0]      visited_q;
  logic              dup_q, dup_d;

  logic [IW-1:0]     a_idx, b_idx;
  logic [CW-1:0]     xa, xb, ya, yb, dx, dy;
  logic [CW:0]       leg;

  assign state_dbg = state_q;

  always_comb begin
    a_idx = snap_q[idx_q];
    b_idx = (idx_q == LAST) ? snap_q[0] : snap_q[idx_q + 1'b1];
    xa    = xs[int'(a_idx) * CW +: CW];
    xb    = xs[int'(b_idx) * CW +: CW];
    ya    = ys[int'(a_idx) * CW +: CW];
    yb    = ys[int'(b_idx) * CW +: CW];
    dx    = (xa >= xb) ? (xa - xb) : (xb - xa);
    dy    = (ya >= yb) ? (ya - yb) : (yb - ya);
    leg   = {1'b0, dx} + {1'b0, dy};
    acc_d = acc_q + OW'(leg);
    dup_d = dup_q | visited_q[a_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      length    <= '0;
      perm_ok   <= 1'b0;
      best      <= '1;
      best_upd  <= 1'b0;
      idx_q     <= '0;
      acc_q     <= '0;
      visited_q <= '0;
      dup_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) snap_q[i] <= path[i*IW +: IW];
            idx_q     <= '0;
            acc_q     <= '0;
            visited_q <= '0;
            dup_q     <= 1'b0;
            busy      <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q            <= acc_d;
          dup_q            <= dup_d;
          visited_q[a_idx] <= 1'b1;
          idx_q            <= idx_q + 1'b1;
          // Last leg: publish the result on the same edge busy falls.
          if (idx_q == LAST) begin
            state_q <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            length  <= acc_d;
            perm_ok <= !dup_d;
            if (!dup_d && (acc_d < best)) begin
              best     <= acc_d;
              best_upd <= 1'b1;
            end
          end
        end
        S_DONE: begin
          done     <= 1'b0;
          best_upd <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tour_length_eval.sv
// Bench for tour_length_eval: a 4-city and a 64-city instance checked against
// a plain-arithmetic tour model with randomized coordinates and paths.
module tb_tour_length_eval;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_c = 1'b0;
  logic sel64 = 1'b0;

  logic [4*8-1:0]   xs4, ys4;
  logic [4*2-1:0]   path4;
  logic [64*8-1:0]  xs64, ys64;
  logic [64*6-1:0]  path64;

  logic start4, start64;
  logic busy4, done4, perm4, upd4;
  logic busy64, done64, perm64, upd64;
  logic [31:0] len4, best4, len64, best64;
  logic [1:0] st4, st64;

  logic busy_c, done_c, perm_c, upd_c;
  logic [31:0] len_c, best_c;

  int mx[64], my[64], mp[64];
  longint best4_m, best64_m;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign start4  = start_c & ~sel64;
  assign start64 = start_c & sel64;
  assign busy_c  = sel64 ? busy64 : busy4;
  assign done_c  = sel64 ? done64 : done4;
  assign perm_c  = sel64 ? perm64 : perm4;
  assign upd_c   = sel64 ? upd64  : upd4;
  assign len_c   = sel64 ? len64  : len4;
  assign best_c  = sel64 ? best64 : best4;

  tour_length_eval #(.N(4), .IW(2), .CW(8), .OW(32)) u4 (
    .clk(clk), .rst(rst), .start(start4), .xs(xs4), .ys(ys4), .path(path4),
    .busy(busy4), .done(done4), .length(len4), .perm_ok(perm4),
    .best(best4), .best_upd(upd4), .state_dbg(st4)
  );

  tour_length_eval #(.N(64), .IW(6), .CW(8), .OW(32)) u64 (
    .clk(clk), .rst(rst), .start(start64), .xs(xs64), .ys(ys64), .path(path64),
    .busy(busy64), .done(done64), .length(len64), .perm_ok(perm64),
    .best(best64), .best_upd(upd64), .state_dbg(st64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint ref_len(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) begin
      int a = mp[i];
      int b = mp[(i + 1) % n];
      s += (mx[a] > mx[b]) ? (mx[a] - mx[b]) : (mx[b] - mx[a]);
      s += (my[a] > my[b]) ? (my[a] - my[b]) : (my[b] - my[a]);
    end
    return s;
  endfunction

  function automatic bit ref_perm(input int n);
    int cnt[64];
    for (int i = 0; i < 64; i++) cnt[i] = 0;
    for (int i = 0; i < n; i++) cnt[mp[i]]++;
    for (int i = 0; i < n; i++) if (cnt[i] != 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load_inputs();
    for (int i = 0; i < 4; i++) begin
      xs4[i*8 +: 8]   = mx[i][7:0];
      ys4[i*8 +: 8]   = my[i][7:0];
      path4[i*2 +: 2] = mp[i][1:0];
    end
    for (int i = 0; i < 64; i++) begin
      xs64[i*8 +: 8]   = mx[i][7:0];
      ys64[i*8 +: 8]   = my[i][7:0];
      path64[i*6 +: 6] = mp[i][5:0];
    end
  endtask

  task automatic set_square();
    mx[0] = 0;  my[0] = 0;
    mx[1] = 10; my[1] = 0;
    mx[2] = 10; my[2] = 10;
    mx[3] = 0;  my[3] = 10;
  endtask

  task automatic set_path4(input int p0, input int p1, input int p2, input int p3);
    mp[0] = p0; mp[1] = p1; mp[2] = p2; mp[3] = p3;
  endtask

  task automatic check_results(input string tag, input logic [31:0] el, input bit eok,
                               input logic [31:0] eb, input bit eupd);
    checks++;
    if (done_c !== 1'b1 || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL %s done/busy: got %b/%b expected 1/0", tag, done_c, busy_c);
    end
    checks++;
    if (len_c !== el) begin
      errors++;
      $display("FAIL %s length: got %0d expected %0d", tag, len_c, el);
    end
    checks++;
    if (perm_c !== eok) begin
      errors++;
      $display("FAIL %s perm_ok: got %b expected %b", tag, perm_c, eok);
    end
    checks++;
    if (best_c !== eb || upd_c !== eupd) begin
      errors++;
      $display("FAIL %s best/best_upd: got %0d/%b expected %0d/%b", tag, best_c, upd_c, eb, eupd);
    end
  endtask

  // Full evaluation of the tour currently held in mx/my/mp.
  task automatic run_eval(input int n, input bit timing, input string tag);
    longint el = ref_len(n);
    bit eok = ref_perm(n);
    longint bm = (n == 64) ? best64_m : best4_m;
    bit eupd = eok && (el < bm);
    if (eupd) bm = el;
    if (n == 64) best64_m = bm; else best4_m = bm;
    sel64 = (n == 64);
    load_inputs();
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    checks++;
    if (busy_c !== 1'b1) begin
      errors++;
      $display("FAIL %s busy after accept: got %b expected 1", tag, busy_c);
    end
    for (int k = 1; k < n; k++) begin
      step();
      if (timing) begin
        checks++;
        if (busy_c !== 1'b1 || done_c !== 1'b0) begin
          errors++;
          $display("FAIL %s run cycle %0d busy/done: got %b/%b expected 1/0", tag, k, busy_c, done_c);
        end
      end
    end
    step();
    check_results(tag, 32'(el), eok, 32'(bm), eupd);
    step();
    checks++;
    if (done_c !== 1'b0 || upd_c !== 1'b0 || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: got done=%b upd=%b busy=%b expected 0/0/0", tag, done_c, upd_c, busy_c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    best4_m  = 64'hFFFF_FFFF;
    best64_m = 64'hFFFF_FFFF;
    checks++;
    if ({busy4, done4, perm4, upd4, busy64, done64, perm64, upd64} !== 8'h00) begin
      errors++;
      $display("FAIL reset flags: got %b expected 00000000",
               {busy4, done4, perm4, upd4, busy64, done64, perm64, upd64});
    end
    checks++;
    if (len4 !== 32'd0 || len64 !== 32'd0) begin
      errors++;
      $display("FAIL reset length: got %0d/%0d expected 0/0", len4, len64);
    end
    checks++;
    if (best4 !== 32'hFFFF_FFFF || best64 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset best: got %h/%h expected ffffffff", best4, best64);
    end
  endtask

  task automatic test_square();
    set_square();
    set_path4(0, 1, 2, 3);
    run_eval(4, 1'b1, "square_identity");
  endtask

  task automatic test_orders();
    set_square();
    set_path4(0, 2, 1, 3);
    run_eval(4, 1'b0, "square_cross");
    set_path4(3, 2, 1, 0);
    run_eval(4, 1'b0, "square_reverse_equal");
  endtask

  task automatic test_dup();
    set_square();
    set_path4(0, 1, 1, 3);
    run_eval(4, 1'b0, "square_dup");
  endtask

  task automatic test_max64();
    longint el;
    for (int i = 0; i < 64; i++) begin
      mx[i] = (i % 2 == 1) ? 255 : 0;
      my[i] = (i % 2 == 1) ? 255 : 0;
      mp[i] = i;
    end
    el = ref_len(64);
    sel64 = 1'b1;
    load_inputs();
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    step();
    step();
    start_c = 1'b1;
    path64 = '0;
    step();
    start_c = 1'b0;
    for (int k = 4; k <= 64; k++) step();
    if (el < best64_m) best64_m = el;
    check_results("max64_ignore_start", 32'(el), 1'b1, 32'(best64_m), 1'b1);
    step();
    step();
    step();
    checks++;
    if (busy64 !== 1'b0 || done64 !== 1'b0) begin
      errors++;
      $display("FAIL max64 start not queued: got busy=%b done=%b expected 0/0", busy64, done64);
    end
    load_inputs();
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      int n = (it % 4 == 3) ? 64 : 4;
      for (int i = 0; i < n; i++) begin
        mx[i] = $urandom_range(255, 0);
        my[i] = $urandom_range(255, 0);
        mp[i] = i;
      end
      for (int i = n - 1; i > 0; i--) begin
        int j = $urandom_range(i, 0);
        int t = mp[i];
        mp[i] = mp[j];
        mp[j] = t;
      end
      if ($urandom_range(2, 0) == 0) mp[$urandom_range(n - 1, 0)] = mp[$urandom_range(n - 1, 0)];
      run_eval(n, 1'b0, (n == 64) ? "random64" : "random4");
    end
  endtask

  task automatic test_mid_reset();
    set_square();
    set_path4(0, 1, 2, 3);
    sel64 = 1'b0;
    load_inputs();
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    best4_m  = 64'hFFFF_FFFF;
    best64_m = 64'hFFFF_FFFF;
    checks++;
    if (busy4 !== 1'b0 || len4 !== 32'd0 || perm4 !== 1'b0 || best4 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b len=%0d perm=%b best=%h expected 0/0/0/ffffffff",
               busy4, len4, perm4, best4);
    end
    run_eval(4, 1'b1, "after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_square();
    test_orders();
    test_dup();
    test_max64();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tour_length_eval.md
Name: tour_length_eval

Overview:
- Scores a candidate TSP tour: sums the closed-loop Manhattan length over the city visit order produced by the tsp solver.
- Checks that the order is a true permutation of all cities.
- Keeps the best valid length seen since reset.
- Sits downstream of tsp (consumes its path plus the shared xs/ys tables); its length/best outputs feed the 7-segment performance display.

Parameters:
- N, 64, number of cities / path entries
- IW, 6, city index width (clog2(N))
- CW, 8, coordinate width
- OW, 32, length/best output width

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request evaluation; sampled only in IDLE
- xs  input  CW x N  city x coordinates; caller holds stable while busy
- ys  input  CW x N  city y coordinates; caller holds stable while busy
- path  input  IW x N  visit order; snapshotted on start acceptance
- busy  output  1  high during RUN
- done  output  1  one-cycle pulse when results update
- length  output  OW  last computed tour length
- perm_ok  output  1  last path visited every city exactly once
- best  output  OW  minimum length over perm_ok results since reset
- best_upd  output  1  one-cycle pulse, coincident with done, when best improves

Behaviour:
- One clock domain (clk). rst is synchronous and active-high and overrides everything.
- Reset values: state=IDLE; busy=0, done=0, length=0, perm_ok=0, best_upd=0; best=all-ones (2^OW-1).
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge T: snapshot path into internal regs; idx=0; acc=0; visited bitmap cleared; dup=0; go to RUN.
  - start=0: stay in IDLE.
- RUN (exactly N cycles, edges T+1..T+N), leg per edge:
  - a=snap[idx], b=snap[(idx+1) mod N]; last leg wraps path[N-1] -> path[0].
  - leg = |xs[a]-xs[b]| + |ys[a]-ys[b]|, computed at CW+1 bits, unsigned absolute difference, no overflow.
  - acc <= acc + leg at OW bits. Max total N*2*(2^CW-1) = 32640 at defaults, so no wrap.
  - Permutation check: if visited[snap[idx]] is already set, dup <= 1; then set visited[snap[idx]].
  - idx increments each edge. When idx==N-1: go to DONE.
- DONE (1 cycle): entered at edge T+N; at that edge outputs update:
  - length = final acc; perm_ok = !dup; done = 1.
  - If perm_ok and length < best: best = length and best_upd = 1. Equal length does not update.
  - Next edge: done=0, best_upd=0, return to IDLE.
  - length/perm_ok/best hold until the next DONE.
- Latency: done high in the cycle after edge T+N, i.e. N+1 edges after start acceptance. Minimum start-to-start spacing is N+2 edges.
- start while RUN or DONE is ignored and not queued.
- Changing path during RUN has no effect (snapshot). Changing xs/ys during RUN gives an undefined result.
- Invalid (duplicate) paths still produce a length; best is never updated from them.
- Mid-operation rst: immediate return to reset values; partial acc discarded; best reset to all-ones.
- busy = (state==RUN). It falls on the same edge at which done rises.

Test Plan:
- N=4; cities (0,0),(10,0),(10,10),(0,10); path 0,1,2,3; start pulse -> busy 4 cycles; done on 5th cycle after start edge; length=40, perm_ok=1, best=40, best_upd=1.
- Same cities, path 0,2,1,3 -> length=60, perm_ok=1, best stays 40, best_upd=0. Re-run path 3,2,1,0 -> length=40, best_upd=0 (equal, no update).
- Same cities, path 0,1,1,3 -> length=40, perm_ok=0, best unchanged, best_upd=0.
- N=64; xs/ys alternate 0/255 by city index; path identity -> length=32640, perm_ok=1. Then pulse start again 3 cycles after acceptance, and alter path during RUN -> second start ignored, result unchanged.
- Assert rst 2 cycles into RUN -> next cycle busy=0, length=0, perm_ok=0, best=FFFFFFFF. A fresh start then completes normally with length=40 (4-city square).
